temporizador_ctrl: RTL and testbench
====================================

Name: temporizador_ctrl

Overview:
- Controller for the RTC countdown-timer function. Holds the timer value as packed BCD hh:mm:ss and decrements it once per 1 Hz tick from the RTC sequencer.
- Sequences load, run, pause and expiry, and drives the alarm.
- Sits between the user-interface FSM, which supplies the setpoint and commands, and the display/RTC write path, which consumes the BCD outputs.

Parameters:
- ALARMA_SEG, 10, number of 1 Hz ticks the alarm stays asserted after expiry without acknowledge (1..255).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick_1hz  in  1  one-clk-wide pulse, once per second
- cargar  in  1  load pulse; latch hora_in/minuto_in/segundo_in
- hora_in  in  8  BCD hours setpoint (00-23)
- minuto_in  in  8  BCD minutes setpoint (00-59)
- segundo_in  in  8  BCD seconds setpoint (00-59)
- iniciar  in  1  start/resume pulse
- detener  in  1  pause pulse
- ack  in  1  alarm acknowledge pulse
- hora_out  out  8  current BCD hours
- minuto_out  out  8  current BCD minutes
- segundo_out  out  8  current BCD seconds
- activo  out  1  high in CONTANDO
- fin  out  1  one-clk pulse on reaching 00:00:00 while counting
- alarma  out  1  level, high in FIN state
- error_carga  out  1  one-clk pulse when a load is rejected

Behaviour:
- Clocking and reset:
  - Single clock domain. All state and outputs are registered.
  - Reset (synchronous, active-high) has priority over everything: state=IDLE, hora/minuto/segundo_out=8'h00, activo=0, fin=0, alarma=0, error_carga=0, alarm tick counter=0.
- States:
  - IDLE: not counting.
  - CONTANDO: decrement on each tick_1hz.
  - PAUSA: value frozen.
  - FIN: alarm active.
- Command priority within one cycle: reset > cargar > detener > iniciar > ack > tick_1hz.
- Load:
  - cargar is accepted in IDLE, PAUSA and FIN. It is ignored in CONTANDO.
  - Validation: any nibble > 9, hours > 23, minutes > 59 or seconds > 59 rejects the load. On reject: error_carga pulses 1 cycle and the value and state are unchanged.
  - Valid load: value takes the setpoint on the next edge; state goes to IDLE; alarma clears.
- Start:
  - iniciar in IDLE or PAUSA with value != 00:00:00 goes to CONTANDO; activo=1 from the next cycle.
  - iniciar with value 00:00:00 is ignored.
  - iniciar is ignored in CONTANDO and FIN.
- Pause: detener in CONTANDO goes to PAUSA; it wins over a tick in the same cycle, so no decrement occurs. detener is ignored in other states.
- Decrement: on tick_1hz in CONTANDO, with result visible the cycle after the tick.
  - BCD borrow chain: seconds units; if 0 → tens-1, units=9; if seconds=00 → 59 and borrow to minutes (same rule); if minutes=00 → 59 and borrow to hours.
  - Hours never underflow, because 00:00:00 is terminal.
  - Example: 01:00:00 → 00:59:59; 00:10:00 → 00:09:59.
- Expiry: a decrement that produces 00:00:00 causes fin=1 for exactly that cycle (coincident with the value update), state → FIN, activo=0, alarma=1.
- FIN:
  - Value is held at 00:00:00.
  - The alarm counter increments on each tick_1hz. When it reaches ALARMA_SEG, alarma=0, state → IDLE, counter cleared.
  - ack in FIN: alarma=0 and → IDLE on the next edge; counter cleared.
  - ack is ignored elsewhere.
- Ticks arriving outside CONTANDO/FIN have no effect.
- Reset mid-count: value returns to 00:00:00 and state to IDLE; the next tick is ignored.
- Outputs are always valid BCD; the value never leaves 00:00:00..23:59:59.

Test Plan:
- Reset, then cargar 12:34:56 → outputs 8'h12/8'h34/8'h56, state IDLE. iniciar, then 3 ticks → 12:34:53, activo=1.
- Load 01:00:00, run, 1 tick → 00:59:59. Load 00:10:00, run, 1 tick → 00:09:59.
- Load 00:00:02, run, 2 ticks → value 00:00:00, fin high exactly 1 cycle, alarma=1, activo=0. Then 10 ticks (ALARMA_SEG=10) → alarma=0, IDLE. Repeat with ack after 3 ticks → alarma=0 immediately next cycle.
- Load 00:00:30 and run, 5 ticks, then detener asserted in the same cycle as a tick → 00:00:25 held. Further ticks give no change. iniciar then 1 tick → 00:00:24.
- Invalid loads 24:00:00, 00:60:00, 00:0A:00, and cargar while in CONTANDO → error_carga 1-cycle pulse for the first three, value unchanged in all four. iniciar with 00:00:00 → stays IDLE.
- Reset asserted mid-count at 05:05:05 → next cycle 00:00:00, IDLE, all flags 0. Following tick_1hz produces no change.

Source files
------------

// File: rtl/temporizador_ctrl.sv
// BCD hh:mm:ss countdown timer: load, run, pause, expiry and alarm sequencing.
// States: IDLE (stopped), CONTANDO (decrementing), PAUSA (frozen), FIN (alarm up).
module temporizador_ctrl #(
  parameter int ALARMA_SEG = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       cargar,
  input  logic [7:0] hora_in,
  input  logic [7:0] minuto_in,
  input  logic [7:0] segundo_in,
  input  logic       iniciar,
  input  logic       detener,
  input  logic       ack,
  output logic [7:0] hora_out,
  output logic [7:0] minuto_out,
  output logic [7:0] segundo_out,
  output logic       activo,
  output logic       fin,
  output logic       alarma,
  output logic       error_carga
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CONTANDO = 2'd1,
    PAUSA    = 2'd2,
    FIN      = 2'd3
  } estado_t;

  localparam logic [7:0] ALARMA_LIM = 8'(ALARMA_SEG);

  estado_t     state_q;
  logic [23:0] valor_q;
  logic [7:0]  cuenta_q;
  logic        activo_q, fin_q, alarma_q, error_q;

  logic [23:0] valor_dec_d;
  logic        carga_valida_d;
  logic        borrow_s, borrow_m;

  // Two-digit BCD decrement; 00 wraps to {tens_wrap, 9}.
  function automatic logic [7:0] dec2(input logic [7:0] v, input logic [3:0] tens_wrap);
    logic [7:0] r;
    if (v[3:0] != 4'd0)
      r = {v[7:4], v[3:0] - 4'd1};
    else if (v[7:4] != 4'd0)
      r = {v[7:4] - 4'd1, 4'd9};
    else
      r = {tens_wrap, 4'd9};
    return r;
  endfunction

  always_comb begin
    borrow_s    = (valor_q[7:0] == 8'h00);
    borrow_m    = borrow_s && (valor_q[15:8] == 8'h00);
    valor_dec_d = valor_q;
    valor_dec_d[7:0] = dec2(valor_q[7:0], 4'd5);
    if (borrow_s)
      valor_dec_d[15:8] = dec2(valor_q[15:8], 4'd5);
    if (borrow_m)
      valor_dec_d[23:16] = dec2(valor_q[23:16], 4'd2);
  end

  // Packed-byte compares are valid BCD bounds once the units nibbles are <= 9.
  always_comb begin
    carga_valida_d = (hora_in <= 8'h23) && (minuto_in <= 8'h59) && (segundo_in <= 8'h59)
                  && (hora_in[3:0] <= 4'd9) && (minuto_in[3:0] <= 4'd9)
                  && (segundo_in[3:0] <= 4'd9);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      valor_q  <= 24'h000000;
      cuenta_q <= 8'd0;
      activo_q <= 1'b0;
      fin_q    <= 1'b0;
      alarma_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      fin_q   <= 1'b0;
      error_q <= 1'b0;
      if (cargar && state_q != CONTANDO) begin
        if (carga_valida_d) begin
          valor_q  <= {hora_in, minuto_in, segundo_in};
          state_q  <= IDLE;
          activo_q <= 1'b0;
          alarma_q <= 1'b0;
          cuenta_q <= 8'd0;
        end else begin
          error_q <= 1'b1;
        end
      end else if (detener && state_q == CONTANDO) begin
        state_q  <= PAUSA;
        activo_q <= 1'b0;
      end else if (iniciar && (state_q == IDLE || state_q == PAUSA)
                   && valor_q != 24'h000000) begin
        state_q  <= CONTANDO;
        activo_q <= 1'b1;
      end else if (ack && state_q == FIN) begin
        state_q  <= IDLE;
        alarma_q <= 1'b0;
        cuenta_q <= 8'd0;
      end else if (tick_1hz) begin
        case (state_q)
          CONTANDO: begin
            valor_q <= valor_dec_d;
            if (valor_dec_d == 24'h000000) begin
              fin_q    <= 1'b1;
              state_q  <= FIN;
              activo_q <= 1'b0;
              alarma_q <= 1'b1;
              cuenta_q <= 8'd0;
            end
          end
          FIN: begin
            if (cuenta_q + 8'd1 == ALARMA_LIM) begin
              state_q  <= IDLE;
              alarma_q <= 1'b0;
              cuenta_q <= 8'd0;
            end else begin
              cuenta_q <= cuenta_q + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign hora_out    = valor_q[23:16];
  assign minuto_out  = valor_q[15:8];
  assign segundo_out = valor_q[7:0];
  assign activo      = activo_q;
  assign fin         = fin_q;
  assign alarma      = alarma_q;
  assign error_carga = error_q;

endmodule

// File: tb/tb_temporizador_ctrl.sv
// Directed bench for temporizador_ctrl with a seconds-count reference model.
module tb_temporizador_ctrl;
  logic clk = 1'b0;
  logic reset, tick_1hz, cargar, iniciar, detener, ack;
  logic [7:0] hora_in, minuto_in, segundo_in;
  logic [7:0] hora_out, minuto_out, segundo_out;
  logic activo, fin, alarma, error_carga;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  temporizador_ctrl #(.ALARMA_SEG(10)) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .cargar(cargar),
    .hora_in(hora_in), .minuto_in(minuto_in), .segundo_in(segundo_in),
    .iniciar(iniciar), .detener(detener), .ack(ack),
    .hora_out(hora_out), .minuto_out(minuto_out), .segundo_out(segundo_out),
    .activo(activo), .fin(fin), .alarma(alarma), .error_carga(error_carga)
  );

  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSA = 2, S_FIN = 3;
  localparam int ALARM_TICKS = 10;

  // Reference: remaining time as a plain number of seconds.
  int m_secs = 0, m_st = S_IDLE, m_cnt = 0;
  bit m_fin = 0, m_err = 0, m_valid = 0;
  int fin_seen = 0;

  function automatic logic [7:0] to_bcd(input int n);
    logic [7:0] r;
    r[7:4] = 4'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  function automatic int bcd_val(input logic [7:0] b);
    if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return -1;
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int h, m, s;
    m_fin = 0;
    m_err = 0;
    h = bcd_val(hora_in);
    m = bcd_val(minuto_in);
    s = bcd_val(segundo_in);
    if (reset) begin
      m_secs = 0; m_st = S_IDLE; m_cnt = 0;
    end else if (cargar && m_st != S_RUN) begin
      if (h >= 0 && h <= 23 && m >= 0 && m <= 59 && s >= 0 && s <= 59) begin
        m_secs = h * 3600 + m * 60 + s;
        m_st = S_IDLE;
        m_cnt = 0;
      end else begin
        m_err = 1;
      end
    end else if (detener && m_st == S_RUN) begin
      m_st = S_PAUSA;
    end else if (iniciar && (m_st == S_IDLE || m_st == S_PAUSA) && m_secs != 0) begin
      m_st = S_RUN;
    end else if (ack && m_st == S_FIN) begin
      m_st = S_IDLE;
      m_cnt = 0;
    end else if (tick_1hz) begin
      if (m_st == S_RUN) begin
        m_secs = m_secs - 1;
        if (m_secs == 0) begin
          m_fin = 1; m_st = S_FIN; m_cnt = 0;
        end
      end else if (m_st == S_FIN) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == ALARM_TICKS) begin
          m_st = S_IDLE; m_cnt = 0;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check("hora", 32'(hora_out), 32'(to_bcd(m_secs / 3600)));
      check("minuto", 32'(minuto_out), 32'(to_bcd((m_secs / 60) % 60)));
      check("segundo", 32'(segundo_out), 32'(to_bcd(m_secs % 60)));
      check("activo", 32'(activo), 32'(m_st == S_RUN));
      check("alarma", 32'(alarma), 32'(m_st == S_FIN));
      check("fin", 32'(fin), 32'(m_fin));
      check("error_carga", 32'(error_carga), 32'(m_err));
      if (fin === 1'b1) fin_seen++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    model_step();
    m_valid = 1;
    reset = 0; tick_1hz = 0; cargar = 0; iniciar = 0; detener = 0; ack = 0;
  endtask

  task automatic load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    cargar = 1; hora_in = h; minuto_in = m; segundo_in = s;
    cyc();
  endtask

  task automatic start();
    iniciar = 1; cyc();
  endtask

  task automatic stop();
    detener = 1; cyc();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1hz = 1; cyc(); cyc(); cyc();
    end
  endtask

  task automatic val(input string name, input logic [23:0] exp);
    check(name, 32'({hora_out, minuto_out, segundo_out}), 32'(exp));
  endtask

  initial begin
    int f0;
    reset = 1; tick_1hz = 0; cargar = 0; iniciar = 0; detener = 0; ack = 0;
    hora_in = 8'h00; minuto_in = 8'h00; segundo_in = 8'h00;
    cyc();
    reset = 1; cyc();
    val("reset_val", 24'h000000);
    check("reset_flags", 32'({activo, fin, alarma, error_carga}), 32'd0);

    load(8'h12, 8'h34, 8'h56);
    val("load_123456", 24'h123456);
    start();
    ticks(3);
    val("run_3ticks", 24'h123453);
    check("run_activo", 32'(activo), 32'd1);

    stop(); load(8'h01, 8'h00, 8'h00); start(); ticks(1);
    val("borrow_hour", 24'h005959);
    stop(); load(8'h00, 8'h10, 8'h00); start(); ticks(1);
    val("borrow_tens", 24'h000959);
    stop(); load(8'h10, 8'h00, 8'h00); start(); ticks(1);
    val("borrow_hour_tens", 24'h095959);
    stop(); load(8'h23, 8'h59, 8'h59); start(); ticks(1);
    val("max_value", 24'h235958);

    // Expiry then alarm timeout.
    stop(); load(8'h00, 8'h00, 8'h02); start(); ticks(1);
    f0 = fin_seen;
    tick_1hz = 1; cyc();
    check("expiry_fin", 32'(fin), 32'd1);
    check("expiry_alarma", 32'(alarma), 32'd1);
    check("expiry_activo", 32'(activo), 32'd0);
    cyc();
    check("fin_one_cycle", 32'(fin), 32'd0);
    ticks(9);
    check("alarma_9ticks", 32'(alarma), 32'd1);
    ticks(1);
    check("alarma_timeout", 32'(alarma), 32'd0);
    check("fin_pulses", 32'(fin_seen - f0), 32'd1);

    // Expiry then acknowledge.
    load(8'h00, 8'h00, 8'h02); start(); ticks(2);
    check("expiry2_alarma", 32'(alarma), 32'd1);
    ticks(3);
    ack = 1; cyc();
    check("ack_alarma", 32'(alarma), 32'd0);
    ticks(1);

    // Pause wins over a coincident tick.
    load(8'h00, 8'h00, 8'h30); start(); ticks(5);
    detener = 1; tick_1hz = 1; cyc();
    val("pause_hold", 24'h000025);
    ticks(3);
    val("pause_ticks", 24'h000025);
    start(); ticks(1);
    val("resume", 24'h000024);

    // Rejected and ignored loads.
    stop();
    load(8'h24, 8'h00, 8'h00);
    check("err_hours", 32'(error_carga), 32'd1);
    load(8'h00, 8'h60, 8'h00);
    check("err_minutes", 32'(error_carga), 32'd1);
    load(8'h00, 8'h0A, 8'h00);
    check("err_nibble", 32'(error_carga), 32'd1);
    val("err_unchanged", 24'h000024);
    start();
    load(8'h01, 8'h00, 8'h00);
    check("load_in_run_err", 32'(error_carga), 32'd0);
    val("load_in_run_val", 24'h000024);

    // Reset mid-count.
    stop(); load(8'h05, 8'h05, 8'h05); start(); cyc();
    reset = 1; cyc();
    val("midreset_val", 24'h000000);
    check("midreset_flags", 32'({activo, fin, alarma, error_carga}), 32'd0);
    ticks(1);
    val("midreset_tick", 24'h000000);
    start();
    check("start_zero", 32'(activo), 32'd0);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
